soc_bus_fabric: RTL and testbench

Parametrised shared-bus interconnect between the single CPU master and N_SLV memory-mapped slaves (data memory, VGA, GPIO, LCD, future peripherals). It replaces the current scheme, where strobes and read data are broadcast to every slave, with the following:
- address decode to a one-hot select
- per-slave gated strobes
- a registered read-data mux
- a variable-latency ready handshake
- a timeout-based bus-error response

---
 rtl/soc_bus_pkg.sv | 32 +++
 rtl/soc_addr_decoder.sv | 39 +++
 rtl/soc_bus_fabric.sv | 187 ++++++++++++++++++
 tb/tb_soc_bus_fabric.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared types and helpers for the SoC bus fabric: FSM state encoding,
// default error read data, timeout counter sizing and packed-slot extraction.
package soc_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } bus_state_e;

   localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;

   // Widest slot and widest packed array get_slot can handle (16 slots).
   localparam int MAX_SLOT_W = 64;
   localparam int SLOT_ARR_W = 16 * MAX_SLOT_W;

   // The counter only needs to reach TIMEOUT-1.
   function automatic int tmo_cnt_w(input int tmo);
      return (tmo <= 2) ? 1 : $clog2(tmo);
   endfunction

   // Slot idx of a packed array of w-bit slots; the caller truncates the
   // result to w bits.
   function automatic logic [MAX_SLOT_W-1:0] get_slot(input logic [SLOT_ARR_W-1:0] arr,
                                                      input int idx,
                                                      input int w);
      logic [SLOT_ARR_W-1:0] shifted;
      shifted = arr >> (idx * w);
      return shifted[MAX_SLOT_W-1:0];
   endfunction

endpackage

// File: rtl/soc_addr_decoder.sv
// Combinational address decoder: per-slot base/mask match reduced to a
// priority one-hot select (lowest index wins) plus an any-hit flag.
module soc_addr_decoder
   import soc_bus_pkg::*;
#(
   parameter int N_SLV  = 4,
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0]       addr,
   input  logic [N_SLV*ADDR_W-1:0] base,
   input  logic [N_SLV*ADDR_W-1:0] mask,
   output logic [N_SLV-1:0]        sel,
   output logic                    hit
);

   logic [N_SLV-1:0] hit_vec;

   generate
      for (genvar gi = 0; gi < N_SLV; gi++) begin : g_match
         assign hit_vec[gi] =
            ((addr & ADDR_W'(get_slot(SLOT_ARR_W'(mask), gi, ADDR_W)))
             == ADDR_W'(get_slot(SLOT_ARR_W'(base), gi, ADDR_W)));
      end
   endgenerate

   // Walk from the top index down so the lowest matching slot is kept.
   always_comb begin
      sel = '0;
      for (int i = N_SLV - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            sel    = '0;
            sel[i] = 1'b1;
         end
      end
   end

   assign hit = |hit_vec;

endmodule

// File: rtl/soc_bus_fabric.sv
// Single-master shared-bus fabric: decodes the master address to one slave,
// gates strobes to that slave only, waits on its ready with a timeout and
// returns registered read data / error status with a one-cycle M_READY.
// Optional error capture registers are enabled with SOC_BUS_ERR_LOG_EN.
module soc_bus_fabric
   import soc_bus_pkg::*;
#(
   parameter int                      N_SLV     = 4,
   parameter int                      ADDR_W    = 32,
   parameter int                      DATA_W    = 32,
   parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE  = '0,
   parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK  = '0,
   parameter int                      TIMEOUT   = 15,
   parameter logic [DATA_W-1:0]       ERR_RDATA = DATA_W'(DEF_ERR_RDATA)
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic [ADDR_W-1:0]       M_ADDR,
   input  logic [DATA_W-1:0]       M_WDATA,
   input  logic                    M_WRSTB,
   input  logic                    M_RDSTB,
   output logic [DATA_W-1:0]       M_RDATA,
   output logic                    M_READY,
   output logic                    M_ERR,
   output logic [ADDR_W-1:0]       S_ADDR,
   output logic [DATA_W-1:0]       S_WDATA,
   output logic [N_SLV-1:0]        S_WRSTB,
   output logic [N_SLV-1:0]        S_RDSTB,
   input  logic [N_SLV*DATA_W-1:0] S_RDATA,
   input  logic [N_SLV-1:0]        S_READY
`ifdef SOC_BUS_ERR_LOG_EN
   ,
   output logic [ADDR_W-1:0]       ERR_ADDR,
   output logic                    ERR_IS_WR,
   output logic                    ERR_VALID,
   input  logic                    ERR_CLR
`endif
);

   localparam int CNT_W = tmo_cnt_w(TIMEOUT);

   bus_state_e        state_reg;
   logic [N_SLV-1:0]  sel_reg;
   logic              is_wr_reg;
   logic [CNT_W-1:0]  cnt_reg;

   logic [N_SLV-1:0]  dec_sel;
   logic              dec_hit;
   logic              req;
   logic              dec_err;
   logic              sel_ready;
   logic              tmo_last;
   logic [DATA_W-1:0] rd_mux;

   soc_addr_decoder #(
      .N_SLV  (N_SLV),
      .ADDR_W (ADDR_W)
   ) u_dec (
      .addr (M_ADDR),
      .base (SLV_BASE),
      .mask (SLV_MASK),
      .sel  (dec_sel),
      .hit  (dec_hit)
   );

   assign req       = M_WRSTB | M_RDSTB;
   assign dec_err   = (M_WRSTB & M_RDSTB) | ~dec_hit;
   assign sel_ready = |(S_READY & sel_reg);
   assign tmo_last  = (cnt_reg == CNT_W'(TIMEOUT - 1));

   // Read-data mux driven by the latched one-hot select only.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (sel_reg[i])
            rd_mux = rd_mux | DATA_W'(get_slot(SLOT_ARR_W'(S_RDATA), i, DATA_W));
      end
   end

   // Transaction FSM; every master and slave output is a register here.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_reg <= IDLE;
         sel_reg   <= '0;
         is_wr_reg <= 1'b0;
         cnt_reg   <= '0;
         M_RDATA   <= '0;
         M_READY   <= 1'b0;
         M_ERR     <= 1'b0;
         S_ADDR    <= '0;
         S_WDATA   <= '0;
         S_WRSTB   <= '0;
         S_RDSTB   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               M_READY <= 1'b0;
               if (req) begin
                  S_ADDR    <= M_ADDR;
                  S_WDATA   <= M_WDATA;
                  is_wr_reg <= M_WRSTB;
                  sel_reg   <= dec_sel;
                  cnt_reg   <= '0;
                  if (dec_err) begin
                     // Ambiguous or unmapped request: answer directly.
                     M_READY   <= 1'b1;
                     M_ERR     <= 1'b1;
                     M_RDATA   <= ERR_RDATA;
                     state_reg <= RESP;
                  end else begin
                     S_WRSTB   <= M_WRSTB ? dec_sel : '0;
                     S_RDSTB   <= M_RDSTB ? dec_sel : '0;
                     state_reg <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (sel_ready) begin
                  M_RDATA   <= is_wr_reg ? '0 : rd_mux;
                  M_ERR     <= 1'b0;
                  M_READY   <= 1'b1;
                  S_WRSTB   <= '0;
                  S_RDSTB   <= '0;
                  state_reg <= RESP;
               end else if (tmo_last) begin
                  M_RDATA   <= ERR_RDATA;
                  M_ERR     <= 1'b1;
                  M_READY   <= 1'b1;
                  S_WRSTB   <= '0;
                  S_RDSTB   <= '0;
                  state_reg <= RESP;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: begin
               // RESP: the M_READY cycle; master strobes are not looked at.
               M_READY   <= 1'b0;
               M_ERR     <= 1'b0;
               M_RDATA   <= '0;
               S_WRSTB   <= '0;
               S_RDSTB   <= '0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

`ifdef SOC_BUS_ERR_LOG_EN
   logic              err_evt;
   logic [ADDR_W-1:0] err_addr_in;
   logic              err_wr_in;

   // Flag the cycle in which the FSM decides to issue an error response.
   always_comb begin
      err_evt     = 1'b0;
      err_addr_in = '0;
      err_wr_in   = 1'b0;
      if (state_reg == IDLE && req && dec_err) begin
         err_evt     = 1'b1;
         err_addr_in = M_ADDR;
         err_wr_in   = M_WRSTB;
      end else if (state_reg == ACCESS && !sel_ready && tmo_last) begin
         err_evt     = 1'b1;
         err_addr_in = S_ADDR;
         err_wr_in   = is_wr_reg;
      end
   end

   // Sticky first-error capture; a clear in the same cycle as a new error
   // lets the new error in.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         ERR_ADDR  <= '0;
         ERR_IS_WR <= 1'b0;
         ERR_VALID <= 1'b0;
      end else if (err_evt && (!ERR_VALID || ERR_CLR)) begin
         ERR_ADDR  <= err_addr_in;
         ERR_IS_WR <= err_wr_in;
         ERR_VALID <= 1'b1;
      end else if (ERR_CLR) begin
         ERR_VALID <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: zero-wait read, wait-state write,
// decode error, timeout, dual-strobe error and mid-access reset.
// Error-log checks are compiled in when SOC_BUS_ERR_LOG_EN is defined.
module tb_soc_bus_fabric;

   localparam int N_SLV  = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   // slot3 0x2..., slot2 0x4..., slot1 0x8..., slot0 0x0...
   localparam logic [N_SLV*ADDR_W-1:0] BASE =
      {32'h2000_0000, 32'h4000_0000, 32'h8000_0000, 32'h0000_0000};
   localparam logic [N_SLV*ADDR_W-1:0] MASK = {4{32'hF000_0000}};

   logic                    aclk = 1'b0;
   logic                    aresetn;
   logic [ADDR_W-1:0]       m_addr;
   logic [DATA_W-1:0]       m_wdata;
   logic                    m_wrstb;
   logic                    m_rdstb;
   logic [DATA_W-1:0]       m_rdata;
   logic                    m_ready;
   logic                    m_err;
   logic [ADDR_W-1:0]       s_addr;
   logic [DATA_W-1:0]       s_wdata;
   logic [N_SLV-1:0]        s_wrstb;
   logic [N_SLV-1:0]        s_rdstb;
   logic [N_SLV*DATA_W-1:0] s_rdata;
   logic [N_SLV-1:0]        s_ready;
`ifdef SOC_BUS_ERR_LOG_EN
   logic [ADDR_W-1:0]       err_addr;
   logic                    err_is_wr;
   logic                    err_valid;
   logic                    err_clr;
`endif

   int n_pass = 0;
   int n_chk  = 0;
   int strobe_cycles;

   always #5 aclk = ~aclk;

   soc_bus_fabric #(
      .N_SLV    (N_SLV),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .SLV_BASE (BASE),
      .SLV_MASK (MASK),
      .TIMEOUT  (15)
   ) dut (
      .ACLK     (aclk),
      .ARESETN  (aresetn),
      .M_ADDR   (m_addr),
      .M_WDATA  (m_wdata),
      .M_WRSTB  (m_wrstb),
      .M_RDSTB  (m_rdstb),
      .M_RDATA  (m_rdata),
      .M_READY  (m_ready),
      .M_ERR    (m_err),
      .S_ADDR   (s_addr),
      .S_WDATA  (s_wdata),
      .S_WRSTB  (s_wrstb),
      .S_RDSTB  (s_rdstb),
      .S_RDATA  (s_rdata),
      .S_READY  (s_ready)
`ifdef SOC_BUS_ERR_LOG_EN
      ,
      .ERR_ADDR  (err_addr),
      .ERR_IS_WR (err_is_wr),
      .ERR_VALID (err_valid),
      .ERR_CLR   (err_clr)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   initial begin
      aresetn = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_wrstb = 1'b0;
      m_rdstb = 1'b0;
      s_ready = '0;
      s_rdata = {32'hCAFE_0003, 32'h2222_2222, 32'h1234_5678, 32'h1111_1111};
`ifdef SOC_BUS_ERR_LOG_EN
      err_clr = 1'b0;
`endif

      // ---- reset state
      tick();
      tick();
      check("rst_m_ready", m_ready, 1'b0);
      check("rst_m_err",   m_err,   1'b0);
      check("rst_m_rdata", m_rdata, 32'h0);
      check("rst_s_wrstb", s_wrstb, 4'b0000);
      check("rst_s_rdstb", s_rdstb, 4'b0000);
      check("rst_s_addr",  s_addr,  32'h0);
      check("rst_s_wdata", s_wdata, 32'h0);
`ifdef SOC_BUS_ERR_LOG_EN
      check("rst_err_valid", err_valid, 1'b0);
`endif
      aresetn = 1'b1;
      tick();

      // ---- zero-wait read of slave 1
      m_addr  = 32'h8000_0010;
      m_rdstb = 1'b1;
      s_ready = 4'b0010;
      tick();                                   // cycle 1: ACCESS
      check("rd0_s_rdstb", s_rdstb, 4'b0010);
      check("rd0_s_wrstb", s_wrstb, 4'b0000);
      check("rd0_s_addr",  s_addr,  32'h8000_0010);
      check("rd0_ready_c1", m_ready, 1'b0);
      tick();                                   // cycle 2: RESP
      check("rd0_ready_c2", m_ready, 1'b1);
      check("rd0_rdata",   m_rdata, 32'h1234_5678);
      check("rd0_err",     m_err,   1'b0);
      check("rd0_strobe_off", s_rdstb, 4'b0000);
      m_rdstb = 1'b0;
      s_ready = '0;
      tick();
      check("rd0_ready_pulse", m_ready, 1'b0);
      $display("txn rd  addr=80000010 done");

      // ---- write to slave 0 with 3 wait cycles; other slaves' ready is noise
      m_addr  = 32'h0000_0100;
      m_wdata = 32'hA5A5_A5A5;
      m_wrstb = 1'b1;
      s_ready = 4'b1110;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("wr_s_wrstb_c%0d", k), s_wrstb, 4'b0001);
         check($sformatf("wr_s_wdata_c%0d", k), s_wdata, 32'hA5A5_A5A5);
         check($sformatf("wr_ready_c%0d", k),   m_ready, 1'b0);
         if (k == 4) s_ready = 4'b0001;
      end
      tick();                                   // cycle 5
      check("wr_ready_c5", m_ready, 1'b1);
      check("wr_err",      m_err,   1'b0);
      check("wr_rdata",    m_rdata, 32'h0);
      check("wr_strobe_off", s_wrstb, 4'b0000);
      m_wrstb = 1'b0;
      s_ready = '0;
      tick();
      $display("txn wr  addr=00000100 data=a5a5a5a5 done");

      // ---- unmapped read
      m_addr  = 32'hF000_0000;
      m_rdstb = 1'b1;
      tick();                                   // cycle 1: RESP
      check("dec_ready", m_ready, 1'b1);
      check("dec_err",   m_err,   1'b1);
      check("dec_rdata", m_rdata, 32'hDEAD_BEEF);
      check("dec_rdstb", s_rdstb, 4'b0000);
      check("dec_wrstb", s_wrstb, 4'b0000);
`ifdef SOC_BUS_ERR_LOG_EN
      check("log_addr",  err_addr,  32'hF000_0000);
      check("log_is_wr", err_is_wr, 1'b0);
      check("log_valid", err_valid, 1'b1);
`endif
      m_rdstb = 1'b0;
      tick();
      $display("txn rd  addr=f0000000 decode error");

      // ---- timeout on slave 2
      m_addr  = 32'h4000_0000;
      m_rdstb = 1'b1;
      s_ready = 4'b1011;
      strobe_cycles = 0;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (s_rdstb == 4'b0100 && !m_ready) strobe_cycles++;
      end
      check("tmo_strobe_cycles", strobe_cycles, 15);
      tick();                                   // cycle 16
      check("tmo_ready", m_ready, 1'b1);
      check("tmo_err",   m_err,   1'b1);
      check("tmo_rdata", m_rdata, 32'hDEAD_BEEF);
      check("tmo_strobe_off", s_rdstb, 4'b0000);
`ifdef SOC_BUS_ERR_LOG_EN
      check("log_sticky_addr", err_addr, 32'hF000_0000);
`endif
      m_rdstb = 1'b0;
      s_ready = '0;
      tick();
      $display("txn rd  addr=40000000 timeout");

`ifdef SOC_BUS_ERR_LOG_EN
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("log_clr_valid", err_valid, 1'b0);
`endif

      // ---- both strobes at once
      m_addr  = 32'h8000_0000;
      m_rdstb = 1'b1;
      m_wrstb = 1'b1;
      tick();
      check("dual_ready", m_ready, 1'b1);
      check("dual_err",   m_err,   1'b1);
      check("dual_wrstb", s_wrstb, 4'b0000);
      check("dual_rdstb", s_rdstb, 4'b0000);
`ifdef SOC_BUS_ERR_LOG_EN
      check("log_dual_is_wr", err_is_wr, 1'b1);
`endif
      m_rdstb = 1'b0;
      m_wrstb = 1'b0;
      tick();
      $display("txn rd+wr addr=80000000 dual-strobe error");

      // ---- reset in the middle of an access to slave 3
      m_addr  = 32'h2000_0004;
      m_rdstb = 1'b1;
      tick();
      check("rstmid_strobe_on", s_rdstb, 4'b1000);
      tick();
      #2;
      aresetn = 1'b0;
      #1;
      check("rstmid_strobe_async", s_rdstb, 4'b0000);
      check("rstmid_ready",        m_ready, 1'b0);
      m_rdstb = 1'b0;
      tick();
      check("rstmid_ready_hold", m_ready, 1'b0);
      aresetn = 1'b1;
      tick();
      check("rstmid_no_ready", m_ready, 1'b0);
      $display("txn rd  addr=20000004 aborted by reset");

      // ---- normal read after reset
      m_addr  = 32'h2000_0004;
      m_rdstb = 1'b1;
      s_ready = 4'b1000;
      tick();
      check("post_strobe", s_rdstb, 4'b1000);
      tick();
      check("post_ready", m_ready, 1'b1);
      check("post_rdata", m_rdata, 32'hCAFE_0003);
      check("post_err",   m_err,   1'b0);
      m_rdstb = 1'b0;
      s_ready = '0;
      tick();
      $display("txn rd  addr=20000004 done");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
